// File: rtl/trans_pkg.sv
// Shared definitions for the transaction pipeline (deframer and validator):
// field widths, the packed transaction word and the deframer state encoding.
package trans_pkg;

  localparam int ID_W    = 48;
  localparam int AMT_W   = 24;
  localparam int CKSUM_W = 8;
  localparam int TRANS_W = 128;

  typedef struct packed {
    logic [ID_W-1:0]    sender;
    logic [ID_W-1:0]    receiver;
    logic [AMT_W-1:0]   amount;
    logic [CKSUM_W-1:0] cksum;
  } trans_t;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_EMIT    = 2'd3
  } state_e;

endpackage

// File: rtl/trans_deframer_if.sv
// Byte-stream input and transaction-word output of trans_deframer.
// Byte side: a byte transfers on a clock edge where byte_valid_i && byte_ready_o;
// word side: valid_o is a one-cycle pulse, held off while busy_i is high (no ready).
interface trans_deframer_if;

  logic [7:0]                  byte_i;
  logic                        byte_valid_i;
  logic                        byte_ready_o;
  logic                        busy_i;
  logic [trans_pkg::TRANS_W-1:0] data_o;
  logic                        valid_o;

  modport master (
    output byte_i, byte_valid_i, busy_i,
    input  byte_ready_o, data_o, valid_o
  );

  modport slave (
    input  byte_i, byte_valid_i, busy_i,
    output byte_ready_o, data_o, valid_o
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter with a build-time choice of saturating at all-ones or wrapping.
module sat_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc_i && !(SAT && (&cnt_q))) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/trans_deframer.sv
// Finds sync-marked 16-byte frames, checks the XOR checksum and emits one word per good frame.
// Optional content filter: define TRANS_DEFRAMER_FILTER_EN (adds drop_cnt_o).
module trans_deframer
  import trans_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 255,
  parameter int         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  trans_deframer_if.slave   bus,
  output logic              cksum_err_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
`ifdef TRANS_DEFRAMER_FILTER_EN
  output logic [CNT_W-1:0]  drop_cnt_o,
`endif
  output state_e            state_o
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [TRANS_W-1:0]   shreg_q, shreg_d;
  logic [TRANS_W-1:0]   data_q, data_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           cksum_q, cksum_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 cerr_q, cerr_d;
  logic                 tout_q, tout_d;
  logic                 drop_d;
  logic                 accept;

  assign accept = bus.byte_valid_i && ready_q;

`ifdef TRANS_DEFRAMER_FILTER_EN
  trans_t word;
  logic   reject;
  assign word   = trans_t'(shreg_q);
  assign reject = (word.sender == word.receiver) || (word.amount == '0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HUNT;
      shreg_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      cksum_q <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      cerr_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cksum_q <= cksum_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      cerr_q  <= cerr_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cksum_d = cksum_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    cerr_d  = 1'b0;
    tout_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (accept && (bus.byte_i == SYNC_BYTE)) begin
          state_d = ST_COLLECT;
          idx_d   = '0;
          cksum_d = '0;
          gap_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          shreg_d = {shreg_q[TRANS_W-9:0], bus.byte_i};
          idx_d   = idx_q + 4'd1;
          gap_d   = '0;
          if (idx_q == 4'd15) begin
            state_d = ST_CHECK;
          end else begin
            cksum_d = cksum_q ^ bus.byte_i;
          end
        end else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
          // TIMEOUT-th consecutive idle cycle: abandon the partial frame.
          tout_d  = 1'b1;
          gap_d   = '0;
          state_d = ST_HUNT;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_CHECK: begin
        if (cksum_q != shreg_q[7:0]) begin
          cerr_d  = 1'b1;
          state_d = ST_HUNT;
`ifdef TRANS_DEFRAMER_FILTER_EN
        end else if (reject) begin
          drop_d  = 1'b1;
          state_d = ST_HUNT;
`endif
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!bus.busy_i) begin
          valid_d = 1'b1;
          data_d  = shreg_q;
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
    // Registered ready tracks the state being entered, so it is low during reset.
    ready_d = (state_d == ST_HUNT) || (state_d == ST_COLLECT);
  end

  sat_counter #(.W(CNT_W), .SAT(1'b0)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (valid_d),
    .cnt_o (frame_cnt_o)
  );

  sat_counter #(.W(CNT_W), .SAT(1'b1)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cerr_d | tout_d),
    .cnt_o (err_cnt_o)
  );

`ifdef TRANS_DEFRAMER_FILTER_EN
  sat_counter #(.W(CNT_W), .SAT(1'b1)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (drop_d),
    .cnt_o (drop_cnt_o)
  );
`else
  logic unused_drop;
  assign unused_drop = drop_d;
`endif

  assign bus.byte_ready_o = ready_q;
  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;
  assign cksum_err_o      = cerr_q;
  assign timeout_o        = tout_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_trans_deframer.sv
// Self-checking bench for trans_deframer: frame scoreboard plus per-scenario tasks.
module tb_trans_deframer;
  import trans_pkg::*;

  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 16;
  localparam logic [127:0] GOOD_W = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BAD_W  = 128'h000102030405060708090A0B0C0D0E10;
  localparam logic [127:0] SYNC_W = 128'h000102A50405060708090A0B0C0D0EA9;

  logic             clk;
  logic             rst;
  logic             cksum_err;
  logic             tout;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
`ifdef TRANS_DEFRAMER_FILTER_EN
  logic [CNT_W-1:0] drop_cnt;
`endif
  state_e           state;

  trans_deframer_if tb_if ();

  trans_deframer #(.SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (tb_if),
    .cksum_err_o (cksum_err),
    .timeout_o   (tout),
    .frame_cnt_o (frame_cnt),
    .err_cnt_o   (err_cnt),
`ifdef TRANS_DEFRAMER_FILTER_EN
    .drop_cnt_o  (drop_cnt),
`endif
    .state_o     (state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int v_cnt  = 0;
  int v_edge = 0;
  int ce_cnt = 0;
  int to_cnt = 0;
  int to_edge = 0;
  int acc_edge = 0;
  logic prev_valid = 1'b0;
  logic [127:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor
  always @(negedge clk) begin
    if (tb_if.valid_o) begin
      v_cnt++;
      v_edge = cyc;
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_word: got %h, scoreboard empty", tb_if.data_o);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (tb_if.data_o !== e) $display("FAIL word_data: got %h exp %h", tb_if.data_o, e);
        else n_pass++;
      end
      if (prev_valid) begin
        n_chk++;
        $display("FAIL valid_width: valid_o high 2 cycles, exp 1");
      end
    end
    if (cksum_err) ce_cnt++;
    if (tout) begin
      to_cnt++;
      to_edge = cyc;
    end
    prev_valid = tb_if.valid_o;
  end

  // drivers
  task automatic send_byte(input logic [7:0] b);
    int n;
    tb_if.byte_i       = b;
    tb_if.byte_valid_i = 1'b1;
    n = 0;
    while (!tb_if.byte_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      $display("FAIL byte_accept: ready stayed 0 for %0d cycles, exp 1", n);
    end
    acc_edge = cyc + 1;
    @(negedge clk);
    tb_if.byte_valid_i = 1'b0;
  endtask

  task automatic send_payload(input logic [127:0] w);
    for (int i = 0; i < 16; i++) send_byte(w[127-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [127:0] w);
    send_byte(8'hA5);
    send_payload(w);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0;
    tb_if.byte_i = '0;
    tb_if.byte_valid_i = 1'b0;
    tb_if.busy_i = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({tb_if.valid_o, tb_if.byte_ready_o, cksum_err, tout} !== 4'b0)
      $display("FAIL reset_pulses: got %b exp 0000", {tb_if.valid_o, tb_if.byte_ready_o, cksum_err, tout});
    else n_pass++;
    n_chk++;
    if ({tb_if.data_o, frame_cnt, err_cnt} !== '0)
      $display("FAIL reset_regs: data %h frame %0d err %0d exp 0", tb_if.data_o, frame_cnt, err_cnt);
    else n_pass++;
    n_chk++;
    if (state !== ST_HUNT) $display("FAIL reset_state: got %0d exp %0d", state, ST_HUNT);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (tb_if.byte_ready_o !== 1'b1) $display("FAIL ready_after_reset: got %b exp 1", tb_if.byte_ready_o);
    else n_pass++;
  endtask

  task automatic test_good_frame();
    int v0;
    v0 = v_cnt;
    exp_q.push_back(GOOD_W);
    send_frame(GOOD_W);
    for (int k = 0; k < 20 && v_cnt == v0; k++) @(negedge clk);
    n_chk++;
    if (v_cnt !== v0 + 1) $display("FAIL good_valid_count: got %0d exp %0d", v_cnt - v0, 1);
    else n_pass++;
    n_chk++;
    if (v_edge - acc_edge !== 2) $display("FAIL good_latency: got %0d exp 2", v_edge - acc_edge);
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'd1) $display("FAIL good_frame_cnt: got %0d exp 1", frame_cnt);
    else n_pass++;
  endtask

  task automatic test_bad_cksum();
    int v0, c0;
    v0 = v_cnt;
    c0 = ce_cnt;
    send_frame(BAD_W);
    repeat (10) @(negedge clk);
    n_chk++;
    if (ce_cnt !== c0 + 1) $display("FAIL cksum_err_pulse: got %0d exp 1", ce_cnt - c0);
    else n_pass++;
    n_chk++;
    if (v_cnt !== v0) $display("FAIL bad_no_valid: got %0d exp 0", v_cnt - v0);
    else n_pass++;
    n_chk++;
    if (err_cnt !== 16'd1) $display("FAIL bad_err_cnt: got %0d exp 1", err_cnt);
    else n_pass++;
  endtask

  task automatic test_junk_sync();
    int v0;
    v0 = v_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    exp_q.push_back(GOOD_W);
    send_frame(GOOD_W);
    exp_q.push_back(SYNC_W);
    send_frame(SYNC_W);
    for (int k = 0; k < 20 && v_cnt < v0 + 2; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_chk++;
    if (v_cnt !== v0 + 2) $display("FAIL junk_valid_count: got %0d exp 2", v_cnt - v0);
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'd3) $display("FAIL junk_frame_cnt: got %0d exp 3", frame_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int t0, v0;
    t0 = to_cnt;
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
    for (int k = 0; k < TIMEOUT + 10 && to_cnt == t0; k++) @(negedge clk);
    n_chk++;
    if (to_cnt !== t0 + 1) $display("FAIL timeout_pulse: got %0d exp 1", to_cnt - t0);
    else n_pass++;
    n_chk++;
    if (to_edge - acc_edge !== TIMEOUT) $display("FAIL timeout_gap: got %0d exp %0d", to_edge - acc_edge, TIMEOUT);
    else n_pass++;
    n_chk++;
    if (err_cnt !== 16'd2) $display("FAIL timeout_err_cnt: got %0d exp 2", err_cnt);
    else n_pass++;
    v0 = v_cnt;
    exp_q.push_back(GOOD_W);
    send_frame(GOOD_W);
    for (int k = 0; k < 20 && v_cnt == v0; k++) @(negedge clk);
    n_chk++;
    if (frame_cnt !== 16'd4) $display("FAIL after_timeout_frame_cnt: got %0d exp 4", frame_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int v0, b0, bad_ready;
    v0 = v_cnt;
    tb_if.busy_i = 1'b1;
    exp_q.push_back(GOOD_W);
    send_frame(GOOD_W);
    tb_if.byte_i = 8'h77;
    tb_if.byte_valid_i = 1'b1;
    bad_ready = 0;
    for (int k = 0; k < 20; k++) begin
      if (tb_if.byte_ready_o !== 1'b0) bad_ready++;
      @(negedge clk);
    end
    n_chk++;
    if (bad_ready !== 0) $display("FAIL busy_ready: ready high %0d cycles exp 0", bad_ready);
    else n_pass++;
    n_chk++;
    if (v_cnt !== v0) $display("FAIL busy_hold: got %0d words exp 0", v_cnt - v0);
    else n_pass++;
    n_chk++;
    if (state !== ST_EMIT) $display("FAIL busy_state: got %0d exp %0d", state, ST_EMIT);
    else n_pass++;
    tb_if.byte_valid_i = 1'b0;
    tb_if.busy_i = 1'b0;
    b0 = cyc;
    for (int k = 0; k < 10 && v_cnt == v0; k++) @(negedge clk);
    n_chk++;
    if (v_edge !== b0 + 1) $display("FAIL busy_release: valid at edge %0d exp %0d", v_edge, b0 + 1);
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'd5) $display("FAIL busy_frame_cnt: got %0d exp 5", frame_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) send_byte(GOOD_W[127-8*i -: 8]);
    v0 = v_cnt;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({tb_if.valid_o, tb_if.byte_ready_o, tb_if.data_o, frame_cnt, err_cnt} !== '0)
      $display("FAIL midreset_outputs: ready %b data %h frame %0d err %0d exp 0",
               tb_if.byte_ready_o, tb_if.data_o, frame_cnt, err_cnt);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back(GOOD_W);
    send_frame(GOOD_W);
    for (int k = 0; k < 20 && v_cnt == v0; k++) @(negedge clk);
    n_chk++;
    if (v_cnt !== v0 + 1) $display("FAIL midreset_valid_count: got %0d exp 1", v_cnt - v0);
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'd1) $display("FAIL midreset_frame_cnt: got %0d exp 1", frame_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_cksum();
    test_junk_sync();
    test_timeout();
    test_backpressure();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    n_chk++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d words left exp 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trans_deframer.md
Name: trans_deframer

Overview:
Upstream stage of trans_validator. It receives the raw transaction byte stream, finds each frame by its sync byte, assembles the 16-byte payload into one 128-bit transaction word and checks its XOR checksum. It presents each good word to the validator as a single-cycle valid pulse. It holds off while the validator is busy, because the validator has no ready of its own.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT, 255, maximum idle cycles allowed between payload bytes before the frame is abandoned.
CNT_W, 16, width of the frame and error counters.

Ports:
clk  input  1  clock.
rst  input  1  reset: asynchronous, active-low.
byte_i  input  8  stream byte.
byte_valid_i  input  1  byte_i is valid.
byte_ready_o  output  1  block can accept a byte; a byte is accepted when byte_valid_i && byte_ready_o.
busy_i  input  1  downstream validator is busy; hold the pending word.
data_o  output  128  transaction word: [127:80] sender id, [79:32] receiver id, [31:8] amount, [7:0] checksum.
valid_o  output  1  one-cycle pulse; data_o is valid in that cycle.
cksum_err_o  output  1  one-cycle pulse on a checksum mismatch.
timeout_o  output  1  one-cycle pulse when a frame is abandoned on timeout.
frame_cnt_o  output  CNT_W  number of frames emitted; wraps.
err_cnt_o  output  CNT_W  checksum errors plus timeouts; saturates at all-ones.

Behaviour:
- Reset (rst low, asynchronous): state=HUNT; all outputs, counters, shift register, index and gap counter are 0.
- byte_ready_o = 1 in HUNT and COLLECT, 0 in CHECK and EMIT.
- HUNT: an accepted byte equal to SYNC_BYTE moves to COLLECT with idx=0, cksum=0, gap=0. Any other byte is discarded.
- COLLECT:
  - Each accepted byte shifts into the 128-bit shift register, MSB-first (the first byte lands in [127:120]).
  - idx increments on each accepted byte; gap clears to 0.
  - cksum ^= byte for idx 0..14.
  - The byte accepted at idx 15 moves to CHECK.
  - A payload byte equal to SYNC_BYTE is treated as data; there is no resync.
  - Each cycle with no accept increments gap. When gap reaches TIMEOUT: timeout_o pulses, err_cnt increments, state returns to HUNT, and the partial frame is discarded.
- CHECK (exactly 1 cycle):
  - If cksum != shreg[7:0]: cksum_err_o pulses, err_cnt increments, state goes to HUNT.
  - Otherwise state goes to EMIT.
- EMIT:
  - While busy_i=1, wait; no timeout applies here.
  - On the first cycle with busy_i=0: register data_o <= shreg, valid_o=1 for one cycle, frame_cnt increments, state goes to HUNT.
- data_o holds its last value between frames.
- Latency: if the last byte is accepted at cycle N, valid_o rises no earlier than cycle N+2.
- err_cnt_o saturates at all-ones. frame_cnt_o wraps to 0.
- cksum_err_o and timeout_o can never assert in the same cycle, because they come from different states.
- Reset asserted mid-frame discards the partial frame; no pulse is produced.

Optional Feature:
TRANS_DEFRAMER_FILTER_EN
- Defined: CHECK also rejects a checksum-good frame when sender id == receiver id, or amount == 0. A rejected frame goes to HUNT with no valid_o and increments an extra output port drop_cnt_o [CNT_W-1:0] (saturating).
- Undefined: no filtering, and the drop_cnt_o port does not exist.

Decomposition:
- Shared package trans_pkg holds:
  - field offsets/widths: ID_W=48, AMT_W=24, CKSUM_W=8, TRANS_W=128;
  - a packed struct trans_t {sender, receiver, amount, cksum};
  - the state enum.
- trans_validator imports the same package.
- One natural sub-module: sat_counter (parameterised width, saturate or wrap selectable), used for all counters.

Test Plan:
- Good frame: A5, 00,01,..,0E, 0F, back-to-back, busy_i=0 -> valid_o one pulse 2 cycles after the last byte; data_o=128'h000102030405060708090A0B0C0D0E0F; frame_cnt_o=1.
- Bad checksum: same frame with last byte 0x10 -> cksum_err_o pulse; no valid_o; err_cnt_o=1.
- Junk then sync: 11,22,A5 followed by the good frame -> exactly one valid_o with the same data; an A5 inside the payload (e.g. byte 3 = A5, last byte 0xA9) is taken as data.
- Timeout: A5 plus 5 bytes, then an idle gap of TIMEOUT cycles -> timeout_o pulse; err_cnt_o=1. A following good frame is emitted normally.
- Backpressure: busy_i=1 held for 20 cycles over the end of a good frame -> byte_ready_o=0 throughout; valid_o rises the cycle busy_i falls; bytes offered meanwhile are not accepted.
- Reset mid-frame: pull rst low after 8 payload bytes -> all outputs 0 immediately; the next good frame is emitted with frame_cnt_o=1.
